// File: rtl/lfsr_range_sampler.sv
// lfsr_range_sampler: draws 32-bit words from an external LFSR, keeps the low
// WIDTH bits, masks them to the smallest power-of-two window covering the
// limit and rejection-samples into [0, limit). Accepted values go into a small
// FIFO presented on a valid/ready output.
// Optional feature macro: SAMPLER_STATS_EN adds a saturating 16-bit
// reject counter output (reject_cnt).
module lfsr_range_sampler #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_wr,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic [31:0]      rnd_in,
  output logic             rnd_en,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy
`ifdef SAMPLER_STATS_EN
  ,
  output logic [15:0]      reject_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] limit_reg;
  logic [WIDTH-1:0] mask_reg;
  logic [CW-1:0]    count_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] mem [DEPTH];

  logic [WIDTH-1:0] cand;
  logic             accept;
  logic             push;
  logic             pop;
  logic             reject;
  logic [CW-1:0]    count_next;
  logic [AW-1:0]    rd_ptr_next;
  logic [WIDTH-1:0] head_next;

  // Only the low WIDTH bits of the LFSR word are meaningful here.
  logic unused_rnd_bits;
  assign unused_rnd_bits = ^rnd_in;

  // Smallest all-ones mask covering lim-1; lim=0 wraps to all-ones, lim=1 gives 0.
  function automatic logic [WIDTH-1:0] mask_for(input logic [WIDTH-1:0] lim);
    logic [WIDTH-1:0] m;
    m = lim - WIDTH'(1);
    for (int s = 1; s < WIDTH; s = s * 2) begin
      m = m | (m >> s);
    end
    return m;
  endfunction

  // Draw/accept decisions and next FIFO head; all from registers except rnd_in,
  // which only feeds registers.
  always_comb begin
    cand        = rnd_in[WIDTH-1:0] & mask_reg;
    accept      = (limit_reg == '0) || (cand < limit_reg);
    rnd_en      = (state_reg == ST_RUN) && (count_reg < CW'(DEPTH));
    out_valid   = (count_reg != '0);
    out_data    = data_reg;
    busy        = (state_reg == ST_FLUSH);
    push        = rnd_en && accept && !cfg_wr;
    reject      = rnd_en && !accept && !cfg_wr;
    pop         = out_valid && out_ready && !cfg_wr;
    count_next  = count_reg + CW'(push) - CW'(pop);
    rd_ptr_next = rd_ptr_reg + AW'(pop);
    head_next   = data_reg;
    if (count_next != '0) begin
      // The pushed word becomes head when the FIFO is (or is about to be) empty;
      // it is not in the array yet, so bypass it.
      if ((count_reg == '0) || ((count_reg == CW'(1)) && pop)) begin
        head_next = cand;
      end else begin
        head_next = mem[rd_ptr_next];
      end
    end
  end

  // Control FSM, limit/mask registers, FIFO pointers and the registered head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      limit_reg  <= '0;
      mask_reg   <= '1;
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      data_reg   <= '0;
    end else if (cfg_wr) begin
      state_reg  <= ST_FLUSH;
      limit_reg  <= cfg_limit;
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE:  state_reg <= en ? ST_RUN : ST_IDLE;
        ST_RUN:   state_reg <= en ? ST_RUN : ST_IDLE;
        ST_FLUSH: begin
          state_reg <= en ? ST_RUN : ST_IDLE;
          mask_reg  <= mask_for(limit_reg);
        end
        default:  state_reg <= ST_IDLE;
      endcase
      count_reg  <= count_next;
      wr_ptr_reg <= wr_ptr_reg + AW'(push);
      rd_ptr_reg <= rd_ptr_next;
      data_reg   <= head_next;
    end
  end

  // FIFO storage; no reset so it maps onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= cand;
    end
  end

`ifdef SAMPLER_STATS_EN
  logic [15:0] reject_cnt_reg;
  assign reject_cnt = reject_cnt_reg;

  // Saturating count of rejected draws since reset or the last reconfiguration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reject_cnt_reg <= '0;
    end else if (cfg_wr) begin
      reject_cnt_reg <= '0;
    end else if (reject && (reject_cnt_reg != 16'hFFFF)) begin
      reject_cnt_reg <= reject_cnt_reg + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_range_sampler.sv
// Scoreboard bench for lfsr_range_sampler (WIDTH=8, DEPTH=4). A behavioural
// 32-bit LFSR seeded 32'h974CA351 supplies rnd_in unless a directed word list
// is active. Expected values are pushed at draw edges and popped on handshakes.
module tb_lfsr_range_sampler;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        cfg_wr;
  logic [7:0]  cfg_limit;
  logic [31:0] rnd_in;
  logic        rnd_en;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        busy;
`ifdef SAMPLER_STATS_EN
  logic [15:0] reject_cnt;
`endif

  lfsr_range_sampler #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_wr    (cfg_wr),
    .cfg_limit (cfg_limit),
    .rnd_in    (rnd_in),
    .rnd_en    (rnd_en),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef SAMPLER_STATS_EN
    , .reject_cnt(reject_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // LFSR model: Galois, advanced 32 steps per consumed word.
  logic [31:0] lfsr_word = 32'h974CA351;
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    for (int k = 0; k < 32; k++) begin
      if (r[0]) r = (r >> 1) ^ 32'hB4BCD35C;
      else      r = r >> 1;
    end
    return r;
  endfunction

  logic [31:0] dir_w [4];
  int          dir_n = 0;
  int          dir_i = 0;

  always_comb begin
    rnd_in = lfsr_word;
    if (dir_i < dir_n) rnd_in = dir_w[dir_i];
  end

  // Expected model state
  logic [7:0] sb_q [$];
  logic [7:0] pop_hist [$];
  logic [7:0] exp_limit = 8'd0;
  logic [7:0] exp_mask  = 8'hFF;
  logic [7:0] first_draw = 8'd0;
  int         draws_cfg = 0;
  int         pops_cfg  = 0;
  bit         exp_valid_next = 1'b0;
  bit         hist_on = 1'b0;
  int         hist_total = 0;
  int         hist [10];

  function automatic logic [7:0] mask_of(input logic [7:0] lim);
    logic [7:0] m;
    if (lim == 8'd0) return 8'hFF;
    m = 8'd0;
    while (m < lim - 8'd1) m = {m[6:0], 1'b1};
    return m;
  endfunction

  // Monitor: samples just before each rising edge.
  always begin
    bit         draw;
    logic [7:0] cand;
    logic [7:0] e;
    @(negedge clk);
    #2;
    draw = 1'b0;
    if (!rst) begin
      sb_q.delete();
      exp_limit      = 8'd0;
      exp_mask       = 8'hFF;
      exp_valid_next = 1'b0;
    end else begin
      if (exp_valid_next) check_value("latency_valid", out_valid, 1);
      exp_valid_next = 1'b0;
      draw = rnd_en;
      if (cfg_wr) begin
        sb_q.delete();
        exp_limit = cfg_limit;
        exp_mask  = mask_of(cfg_limit);
        draws_cfg = 0;
        pops_cfg  = 0;
      end else begin
        if (out_valid && out_ready) begin
          pops_cfg++;
          if (sb_q.size() == 0) begin
            check_value("sb_nonempty", sb_q.size(), 1);
          end else begin
            e = sb_q.pop_front();
            check_value("data", out_data, e);
            if (exp_limit != 8'd0) check_value("range", out_data < exp_limit, 1);
            pop_hist.push_back(out_data);
            if (hist_on && hist_total < 10000 && out_data < 8'd10) begin
              hist[out_data]++;
              hist_total++;
            end
          end
        end
        if (draw) begin
          cand = rnd_in[7:0] & exp_mask;
          if (draws_cfg == 0) first_draw = rnd_in[7:0];
          draws_cfg++;
          if (exp_limit == 8'd0 || cand < exp_limit) begin
            sb_q.push_back(cand);
            exp_valid_next = 1'b1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    if (draw) begin
      if (dir_i < dir_n) dir_i++;
      else lfsr_word = lfsr_next(lfsr_word);
    end
  end

  task automatic wait_negs(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_draws(input string tag, input int target, input int budget);
    int c;
    c = 0;
    while (draws_cfg < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (draws_cfg < target) check_value(tag, draws_cfg, target);
  endtask

  task automatic configure(input logic [7:0] lim);
    @(negedge clk);
    cfg_wr    = 1'b1;
    cfg_limit = lim;
    @(negedge clk);
    cfg_wr    = 1'b0;
  endtask

  initial begin
    int c;
    for (int i = 0; i < 10; i++) hist[i] = 0;
    rst = 1'b0; en = 1'b0; cfg_wr = 1'b0; cfg_limit = 8'd0; out_ready = 1'b0;

    // Reset state
    wait_negs(3);
    check_value("rst_rnd_en", rnd_en, 0);
    check_value("rst_out_valid", out_valid, 0);
    check_value("rst_out_data", out_data, 0);
    check_value("rst_busy", busy, 0);
    rst = 1'b1;
    wait_negs(3);
    check_value("idle_rnd_en", rnd_en, 0);
    check_value("idle_out_valid", out_valid, 0);

    // Rejection with limit 10
    dir_w[0] = 32'h5A5A1103; dir_w[1] = 32'h1234560C;
    dir_w[2] = 32'hCAFEBA29; dir_w[3] = 32'h0BADF0FF;
    dir_i = 0; dir_n = 4;
    configure(8'd10);
    check_value("cfg10_busy", busy, 1);
    check_value("cfg10_valid", out_valid, 0);
    pop_hist.delete();
    en = 1'b1; out_ready = 1'b1;
    wait_draws("rej_draw_timeout", 4, 20);
`ifdef SAMPLER_STATS_EN
    check_value("rej_reject_cnt", reject_cnt, 2);
`endif
    check_value("rej_out0", (pop_hist.size() > 0) ? pop_hist[0] : 8'hEE, 3);
    check_value("rej_out1", (pop_hist.size() > 1) ? pop_hist[1] : 8'hEE, 9);

    // Full and backpressure with limit 0
    @(negedge clk);
    out_ready = 1'b0;
    configure(8'd0);
    wait_draws("full_draw_timeout", 4, 20);
    wait_negs(5);
    check_value("full_draws", draws_cfg, 4);
    check_value("full_rnd_en", rnd_en, 0);
    check_value("full_valid", out_valid, 1);
    check_value("full_head", out_data, first_draw);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    wait_negs(5);
    check_value("bp_draws", draws_cfg, 5);
    check_value("bp_rnd_en", rnd_en, 0);

    // Flush with 3 buffered entries
    en = 1'b0;
    wait_negs(2);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    wait_negs(2);
    check_value("pre_flush_valid", out_valid, 1);
    configure(8'd2);
    check_value("flush_busy", busy, 1);
    check_value("flush_valid", out_valid, 0);
    en = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check_value("post_flush_busy", busy, 0);
    wait_negs(40);

    // Boundary limit 1: every draw accepted as 0
    configure(8'd1);
    wait_negs(30);
    en = 1'b0;
    wait_negs(6);
    check_value("lim1_all_accepted", pops_cfg, draws_cfg);
    check_value("lim1_drained", out_valid, 0);
    check_value("lim1_head", out_data, 0);

    // Asynchronous reset mid-run with two entries buffered
    out_ready = 1'b0;
    en = 1'b1;
    configure(8'd0);
    wait_draws("arst_draw_timeout", 2, 20);
    check_value("arst_pre_valid", out_valid, 1);
    #1 rst = 1'b0;
    #1;
    check_value("arst_valid", out_valid, 0);
    check_value("arst_rnd_en", rnd_en, 0);
    check_value("arst_data", out_data, 0);
    en = 1'b0;
    wait_negs(2);
    rst = 1'b1;
    wait_negs(3);
    check_value("arst_after_valid", out_valid, 0);

    // Long run with limit 10: range and distribution
    en = 1'b1; out_ready = 1'b1;
    configure(8'd10);
    hist_on = 1'b1;
    c = 0;
    while (hist_total < 10000 && c < 40000) begin
      @(negedge clk);
      c++;
    end
    check_value("hist_total", hist_total, 10000);
    for (int v = 0; v < 10; v++) begin
      check_value($sformatf("hist_%0d_count_%0d_in_850_1150", v, hist[v]),
                  (hist[v] >= 850 && hist[v] <= 1150), 1);
    end
    en = 1'b0;
    wait_negs(8);
    check_value("final_drained", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_range_sampler.md
Name: lfsr_range_sampler

Overview:
- Downstream consumer of the 32-bit `lfsr` random stream.
- Draws raw words through the LFSR's `en` input and reduces each word to WIDTH bits.
- Rejection-samples the reduced value into the range [0, limit); accepted values are buffered in a small FIFO and presented on a valid/ready output.
- Used wherever the design needs unbiased bounded random numbers, for example random slot or index selection.

Parameters:
- WIDTH, 8: output value width; takes the low WIDTH bits of `rnd_in`. Legal range 1..32.
- DEPTH, 4: output FIFO depth in entries; must be a power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- en  in  1  sampler enable. When low, no new words are drawn; the FIFO still drains.
- cfg_wr  in  1  one-cycle strobe; loads `cfg_limit` and flushes the FIFO.
- cfg_limit  in  WIDTH  exclusive upper bound N. 0 means the full 2^WIDTH range.
- rnd_in  in  32  current LFSR word; connects to lfsr `random`.
- rnd_en  out  1  draw request; connects to lfsr `en`.
- out_valid  out  1  FIFO not empty.
- out_data  out  WIDTH  FIFO head value.
- out_ready  in  1  consumer accepts the head.
- busy  out  1  high in ST_FLUSH.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=ST_IDLE; limit_r=0; mask_r=all-ones.
  - FIFO pointers and count=0.
  - rnd_en=0, out_valid=0, out_data=0, busy=0.
- States and transitions:
  - ST_IDLE → ST_RUN when en=1.
  - ST_RUN → ST_IDLE when en=0.
  - Any state → ST_FLUSH on cfg_wr=1.
  - ST_FLUSH lasts exactly 1 cycle, then goes to ST_RUN if en=1, else ST_IDLE.
- Entering ST_FLUSH:
  - limit_r ← cfg_limit.
  - FIFO count and pointers cleared.
  - out_valid=0 during ST_FLUSH.
  - An out_ready in that cycle is ignored.
- mask_r is registered during ST_FLUSH:
  - limit_r=0 or limit_r=1: mask = all-ones or 0 respectively.
  - Otherwise: mask = 2^(floor(log2(limit_r-1))+1) - 1, the smallest all-ones mask ≥ limit_r-1.
  - Examples: limit 10 → 0x0F; limit 16 → 0x0F; limit 17 → 0x1F; limit 2 → 0x01.
- Draw rule:
  - rnd_en = (state==ST_RUN) && (count<DEPTH); combinational from registers only.
  - At each clock edge with rnd_en=1, the sampler consumes the current `rnd_in`; the LFSR advances on the same edge. Each word is therefore used exactly once.
- Candidate and acceptance:
  - cand = rnd_in[WIDTH-1:0] & mask_r.
  - Accept if limit_r==0 or cand < limit_r; accepted cand is pushed into the FIFO on that edge.
  - Rejected words are discarded and the draw repeats on the next cycle.
- Latency:
  - Accepted value appears on out_data, with out_valid=1, in the cycle after its draw edge.
  - No combinational path from rnd_in to out_*.
- Pop: on an edge with out_valid && out_ready.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Full (count==DEPTH):
  - rnd_en=0, even if a pop occurs in the same cycle; drawing resumes the cycle after count drops.
  - No overflow is possible.
- Empty: out_valid=0, out_data holds its last value, out_ready ignored.
- en falling mid-run: no further draws; buffered values remain poppable.
- cfg_wr while the FIFO holds data: all entries are discarded. Values drawn with the old limit never emerge after cfg_wr.
- Reset mid-operation: immediate return to reset values, independent of clk.

Optional Feature:
- Macro: SAMPLER_STATS_EN.
- Defined:
  - Adds output port `reject_cnt` (16 bits): counts rejected draws.
  - Saturates at 0xFFFF.
  - Cleared by reset and by cfg_wr.
  - Increments by 1 on each draw edge whose candidate is rejected.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset check: hold rst=0, toggle clk. Required: rnd_en=0, out_valid=0, out_data=0, busy=0. Release rst with en=0: rnd_en stays 0.
- Rejection, WIDTH=8:
  - Stimulus: cfg_wr with cfg_limit=10, then en=1, out_ready=1. Drive rnd_in low bytes 0x03, 0x0C, 0x29, 0xFF on successive draw edges.
  - Required: mask 0x0F; candidates 3, 12, 9, 15; outputs 3 then 9, each one cycle after its draw. With SAMPLER_STATS_EN, reject_cnt=2.
- Full and backpressure:
  - Stimulus: limit 0, out_ready=0, en=1.
  - Required: exactly 4 draws, then rnd_en=0. out_data equals the first rnd_in[7:0] drawn. After a single out_ready pulse, exactly one more draw occurs.
- Flush:
  - Stimulus: FIFO holding 3 entries, pulse cfg_wr with cfg_limit=2.
  - Required: busy=1 and out_valid=0 for one cycle. Every subsequent out_data is in {0,1}, and none of the 3 old values appear.
- Boundary limit 1: every draw is accepted and every out_data=0.
- Asynchronous reset mid-run: assert rst between clk edges while count=2. Required: out_valid=0 and rnd_en=0 immediately; after release the FIFO is empty.
- Bench requirements:
  - Cross-check against a real `lfsr` instance seeded 32'h974CA351.
  - Over 10000 outputs with limit 10, every value is <10.
  - Each value appears 1000±150 times.
